// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word per FETCH, presents it in HOLD,
// and selects the next PC (jump > branch > sequential) when downstream releases it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic        pc_j,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic [31:0] instr_count
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign func      = instr[5:0];

    always_comb begin
        pc_plus4 = pc_out + 32'd4;
        br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc  = pc_plus4;
        if (pc_j)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (pc_src)
            next_pc = pc_plus4 + br_off;
    end

    // imem_req is registered so it is low throughout reset; the first FETCH
    // cycle after reset only raises it, so stale ready/data cannot be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_count <= instr_count + 32'd1;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a driver pushes expected presentations from a
// PC-sequence model, a monitor pops and compares when a new instruction appears.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_src;
    logic        pc_j;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic [31:0] instr_count;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .pc_src(pc_src), .pc_j(pc_j), .instr(instr), .opcode(opcode), .func(func),
        .pc_out(pc_out), .instr_valid(instr_valid), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_pres  = 0;
    int unsigned cyc     = 0;
    int unsigned vcyc_last = 0;
    bit          chk_en = 1'b0;
    bit          prev_valid = 1'b0;
    bit          directed = 1'b1;
    bit          force_noready = 1'b0;
    int unsigned wait_n = 0;
    int unsigned hold_n = 0;
    logic [31:0] model_pc;
    logic [31:0] model_cnt;
    bit          dir_src[16];
    bit          dir_j[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory image: a few hand-placed control-flow words, pseudo-random elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h1000_FFFC;
            32'h0000_0020: return 32'h0800_0040;
            32'h0000_0104: return 32'h1000_FFBD;
            default:       return (a * 32'h9E37_79B1) ^ 32'h3C6E_F372;
        endcase
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] p, input logic [31:0] w,
                                            input bit src, input bit j);
        logic [31:0] p4;
        int          off;
        p4  = p + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (j)   return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (src) return p4 + 32'(off);
        return p4;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.pc  = model_pc;
        e.w   = mem_word(model_pc);
        e.cnt = model_cnt;
        q.push_back(e);
    endtask

    task automatic drive_cycle();
        bit rdy, st, s, j;
        if (imem_req) begin
            if (force_noready) rdy = 1'b0;
            else if (directed) rdy = !(model_cnt == 32'd3 && wait_n < 5);
            else rdy = ($urandom_range(0, 9) < 6);
            if (directed && model_cnt == 32'd3 && !rdy) wait_n++;
        end else begin
            rdy = ($urandom_range(0, 1) == 1);
        end
        imem_ready = rdy;
        imem_rdata = (rdy && imem_req) ? mem_word(imem_addr) : $urandom();
        if (instr_valid) begin
            st = directed ? (model_cnt == 32'd2 && hold_n < 3) : ($urandom_range(0, 9) < 3);
            hold_n++;
            if (st) begin
                stall  = 1'b1;
                pc_src = ($urandom_range(0, 1) == 1);
                pc_j   = ($urandom_range(0, 1) == 1);
            end else begin
                if (directed && model_cnt < 16) begin
                    s = dir_src[model_cnt];
                    j = dir_j[model_cnt];
                end else begin
                    s = ($urandom_range(0, 2) == 0);
                    j = ($urandom_range(0, 3) == 0);
                end
                stall  = 1'b0;
                pc_src = s;
                pc_j   = j;
                model_pc  = next_of(model_pc, mem_word(model_pc), s, j);
                model_cnt = model_cnt + 32'd1;
                push_expected();
                hold_n = 0;
                if (model_cnt >= 16) directed = 1'b0;
            end
        end else begin
            stall  = ($urandom_range(0, 1) == 1);
            pc_src = ($urandom_range(0, 1) == 1);
            pc_j   = ($urandom_range(0, 1) == 1);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) begin
                if (imem_req) begin
                    if (q.size() == 0) chk("addr_noexp", imem_addr, 32'hXXXX_XXXX);
                    else chk("imem_addr", imem_addr, q[0].pc);
                end
                if (instr_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        chk("present_noexp", pc_out, 32'hXXXX_XXXX);
                    end else begin
                        cur = q.pop_front();
                        chk("instr", instr, cur.w);
                        chk("pc_out", pc_out, cur.pc);
                        chk("opcode", 32'(opcode), 32'(cur.w[31:26]));
                        chk("func", 32'(func), 32'(cur.w[5:0]));
                        chk("instr_count", instr_count, cur.cnt);
                        if (n_pres == 1 || n_pres == 2) chk("gap_2cyc", cyc - vcyc_last, 2);
                        if (n_pres == 3) chk("gap_stall_wait", cyc - vcyc_last, 10);
                        vcyc_last = cyc;
                        n_pres++;
                    end
                end else if (instr_valid) begin
                    chk("hold_instr", instr, cur.w);
                    chk("hold_pc_out", pc_out, cur.pc);
                    chk("hold_count", instr_count, cur.cnt);
                end
                if (instr_valid) chk("hold_req", 32'(imem_req), 0);
                if (imem_req) chk("fetch_valid", 32'(instr_valid), 0);
                prev_valid = instr_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    // Driver
    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) begin
            dir_src[i] = (i == 4 || i == 12 || i == 14);
            dir_j[i]   = (i == 12);
        end
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0; pc_src = 1'b0; pc_j = 1'b0;
        model_pc = RST_PC; model_cnt = '0;
        push_expected();
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_count", instr_count, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive_cycle();
        end
        chk("progress", 32'(model_cnt > 32'd300), 1);

        force_noready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            drive_cycle();
            seen = imem_req;
        end
        chk("reach_fetch", 32'(seen), 1);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_req), 0);
        chk("midrst_addr", imem_addr, RST_PC);
        chk("midrst_pc_out", pc_out, RST_PC);
        chk("midrst_instr", instr, 0);
        chk("midrst_valid", 32'(instr_valid), 0);
        chk("midrst_count", instr_count, 0);
        force_noready = 1'b0;
        @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        q.delete();
        model_pc = RST_PC; model_cnt = '0; hold_n = 0;
        push_expected();
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            drive_cycle();
        end
        chk("progress_after_rst", 32'(model_cnt > 32'd20), 1);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
